dsm_cic_decimator: RTL and testbench

- Receive-side counterpart of the team's 1-bit first-order delta-sigma modulator: turns the 1-bit DSM bitstream back into signed WIDTH-bit PCM samples.
- Sinc^ORDER CIC decimator: integrators run at bit rate, combs run at sample rate (1/DECIM).
- Sits at the end of the DAC loopback/verification path and in ADC-style capture paths.
- AXI-Stream style in and out; the output stage has one-entry buffering with backpressure.

---
 rtl/dsm_cic_decimator_if.sv | 30 +++
 rtl/dsm_cic_decimator.sv | 90 +++++++++
 tb/tb_dsm_cic_decimator.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsm_cic_decimator_if.sv
// AXI-Stream bundle for the DSM CIC decimator: 1-bit DSM input stream
// and signed PCM output stream (master = source side, slave = decimator).
interface dsm_cic_decimator_if #(
    parameter int WIDTH = 16
);
    logic             s_axis_bit_tdata;
    logic             s_axis_bit_tvalid;
    logic             s_axis_bit_tready;
    logic [WIDTH-1:0] m_axis_data_tdata;
    logic             m_axis_data_tvalid;
    logic             m_axis_data_tready;

    modport master (
        output s_axis_bit_tdata,
        output s_axis_bit_tvalid,
        input  s_axis_bit_tready,
        input  m_axis_data_tdata,
        input  m_axis_data_tvalid,
        output m_axis_data_tready
    );

    modport slave (
        input  s_axis_bit_tdata,
        input  s_axis_bit_tvalid,
        output s_axis_bit_tready,
        output m_axis_data_tdata,
        output m_axis_data_tvalid,
        input  m_axis_data_tready
    );
endinterface

// File: rtl/dsm_cic_decimator.sv
// Sinc^ORDER CIC decimator turning a 1-bit DSM stream into signed PCM.
// Ports: aclk, arst_n (async active-low), axis (slave: bit in, PCM out).
module dsm_cic_decimator #(
    parameter int WIDTH = 16,
    parameter int DECIM = 64,
    parameter int ORDER = 2
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    dsm_cic_decimator_if.slave   axis
);
    localparam int R   = $clog2(DECIM);
    localparam int AW  = ORDER * R + 2;
    localparam int S   = ORDER * R - (WIDTH - 2);
    localparam int SHR = (S > 0) ? S : 0;
    localparam int SHL = (S > 0) ? 0 : -S;
    localparam int EW  = AW + WIDTH;

    logic [R-1:0]           r_phase;
    logic signed [AW-1:0]   r_integ [ORDER];
    logic signed [AW-1:0]   r_dly   [ORDER];
    logic [WIDTH-1:0]       r_odata;
    logic                   r_ovalid;

    logic signed [AW-1:0]   w_step;
    logic signed [AW-1:0]   w_integ_nx [ORDER];
    logic signed [AW-1:0]   w_comb     [ORDER];
    logic signed [AW-1:0]   w_dly_in   [ORDER];
    logic signed [EW-1:0]   w_ext;
    logic signed [WIDTH-1:0] w_scaled;
    logic                   w_last;
    logic                   w_ready;
    logic                   w_acc;

    // DECIM is a power of two, so the last phase is all-ones.
    assign w_last  = &r_phase;
    assign w_ready = !r_ovalid || axis.m_axis_data_tready || !w_last;
    assign w_acc   = axis.s_axis_bit_tvalid && w_ready;

    always_comb begin
        // 1 -> +1, 0 -> -1 (all-ones)
        w_step = {{(AW-1){~axis.s_axis_bit_tdata}}, 1'b1};
        w_integ_nx[0] = r_integ[0] + w_step;
        for (int k = 1; k < ORDER; k++) begin
            w_integ_nx[k] = r_integ[k] + w_integ_nx[k-1];
        end
        w_dly_in[0] = w_integ_nx[ORDER-1];
        w_comb[0]   = w_integ_nx[ORDER-1] - r_dly[0];
        for (int k = 1; k < ORDER; k++) begin
            w_dly_in[k] = w_comb[k-1];
            w_comb[k]   = w_comb[k-1] - r_dly[k];
        end
        w_ext    = {{WIDTH{w_comb[ORDER-1][AW-1]}}, w_comb[ORDER-1]};
        // Exactly one of SHR/SHL is non-zero; unity density -> 2^(WIDTH-2)
        w_scaled = WIDTH'((w_ext >>> SHR) <<< SHL);
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_phase  <= '0;
            r_odata  <= '0;
            r_ovalid <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                r_integ[k] <= '0;
                r_dly[k]   <= '0;
            end
        end else begin
            if (w_acc) begin
                r_phase <= r_phase + 1'b1;
                for (int k = 0; k < ORDER; k++) begin
                    r_integ[k] <= w_integ_nx[k];
                end
            end
            // A new sample wins over the downstream pop: no bubble.
            if (w_acc && w_last) begin
                for (int k = 0; k < ORDER; k++) begin
                    r_dly[k] <= w_dly_in[k];
                end
                r_odata  <= w_scaled;
                r_ovalid <= 1'b1;
            end else if (axis.m_axis_data_tready) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    assign axis.s_axis_bit_tready  = w_ready;
    assign axis.m_axis_data_tdata  = r_odata;
    assign axis.m_axis_data_tvalid = r_ovalid;
endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator (WIDTH=16, DECIM=64, ORDER=2).
// Drives inputs #1 after posedge; samples outputs between edges.
module tb_dsm_cic_decimator;
    localparam int WIDTH = 16;
    localparam int DECIM = 64;
    localparam int ORDER = 2;
    localparam int BOUND = 200;

    logic aclk   = 1'b0;
    logic arst_n = 1'b1;
    int   n_vec  = 0;
    int   n_err  = 0;

    dsm_cic_decimator_if #(.WIDTH(WIDTH)) axis ();

    dsm_cic_decimator #(
        .WIDTH (WIDTH),
        .DECIM (DECIM),
        .ORDER (ORDER)
    ) dut (
        .aclk   (aclk),
        .arst_n (arst_n),
        .axis   (axis.slave)
    );

    always #5 aclk = ~aclk;

    task automatic do_reset;
        axis.s_axis_bit_tvalid  = 1'b0;
        axis.s_axis_bit_tdata   = 1'b0;
        axis.m_axis_data_tready = 1'b1;
        @(negedge aclk);
        arst_n = 1'b0;
        repeat (2) @(negedge aclk);
        arst_n = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic push_bit(input logic b);
        int n;
        n = 0;
        axis.s_axis_bit_tdata  = b;
        axis.s_axis_bit_tvalid = 1'b1;
        @(negedge aclk);
        while (!axis.s_axis_bit_tready && n < BOUND) begin
            n++;
            @(negedge aclk);
        end
        if (n >= BOUND) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout got ready=0 want ready=1");
        end
        @(posedge aclk);
        #1;
        axis.s_axis_bit_tvalid = 1'b0;
    endtask

    task automatic push_n(input logic b, input int n);
        for (int i = 0; i < n; i++) push_bit(b);
    endtask

    task automatic idle(input int n);
        axis.s_axis_bit_tvalid = 1'b0;
        axis.s_axis_bit_tdata  = 1'($urandom);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        arst_n = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tvalid got %b want 0",
                     axis.m_axis_data_tvalid);
        end
        n_vec++;
        if (axis.m_axis_data_tdata !== 16'd0) begin
            n_err++;
            $display("FAIL reset_tdata got %0d want 0",
                     axis.m_axis_data_tdata);
        end
        do_reset();
        n_vec++;
        if (axis.s_axis_bit_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tready got %b want 1",
                     axis.s_axis_bit_tready);
        end
    endtask

    task automatic test_all_ones;
        int exp_v [4] = '{8320, 16384, 16384, 16384};
        logic [WIDTH-1:0] e;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            push_n(1'b1, DECIM - 1);
            if (f == 0) begin
                n_vec++;
                if (axis.m_axis_data_tvalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL ones_early_valid got %b want 0",
                             axis.m_axis_data_tvalid);
                end
            end
            push_bit(1'b1);
            e = WIDTH'(exp_v[f]);
            n_vec++;
            if (axis.m_axis_data_tvalid !== 1'b1 ||
                axis.m_axis_data_tdata !== e) begin
                n_err++;
                $display("FAIL ones[%0d] got v=%b d=%0d want v=1 d=%0d", f,
                         axis.m_axis_data_tvalid,
                         $signed(axis.m_axis_data_tdata), $signed(e));
            end
        end
        push_bit(1'b1);
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL ones_valid_clear got %b want 0",
                     axis.m_axis_data_tvalid);
        end
    endtask

    task automatic test_all_zeros;
        int exp_v [3] = '{-8320, -16384, -16384};
        logic [WIDTH-1:0] e;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            push_n(1'b0, DECIM);
            e = WIDTH'(exp_v[f]);
            n_vec++;
            if (axis.m_axis_data_tvalid !== 1'b1 ||
                axis.m_axis_data_tdata !== e) begin
                n_err++;
                $display("FAIL zeros[%0d] got v=%b d=%0d want v=1 d=%0d", f,
                         axis.m_axis_data_tvalid,
                         $signed(axis.m_axis_data_tdata), $signed(e));
            end
        end
    endtask

    task automatic test_alternating;
        // First frame: integrator2 = 32 -> 128; afterwards combs cancel.
        int exp_v [3] = '{128, 0, 0};
        logic [WIDTH-1:0] e;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < DECIM / 2; i++) begin
                push_bit(1'b1);
                push_bit(1'b0);
            end
            e = WIDTH'(exp_v[f]);
            n_vec++;
            if (axis.m_axis_data_tvalid !== 1'b1 ||
                axis.m_axis_data_tdata !== e) begin
                n_err++;
                $display("FAIL alt[%0d] got v=%b d=%0d want v=1 d=%0d", f,
                         axis.m_axis_data_tvalid,
                         $signed(axis.m_axis_data_tdata), $signed(e));
            end
        end
    endtask

    task automatic test_loopback;
        int   acc;
        int   got;
        logic b;
        acc = 0;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < DECIM; i++) begin
                b   = (acc >= 0);
                acc = acc + 4096 - (b ? 16384 : -16384);
                push_bit(b);
            end
            if (f >= 3) begin
                got = int'($signed(axis.m_axis_data_tdata));
                n_vec++;
                if (axis.m_axis_data_tvalid !== 1'b1 ||
                    got < 3584 || got > 4608) begin
                    n_err++;
                    $display("FAIL loop[%0d] got v=%b d=%0d want 3584..4608",
                             f, axis.m_axis_data_tvalid, got);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int stall;
        stall = 0;
        do_reset();
        push_n(1'b1, DECIM);
        axis.m_axis_data_tready = 1'b0;
        for (int i = 0; i < DECIM - 1; i++) begin
            if (!axis.s_axis_bit_tready) stall++;
            push_bit(1'b1);
        end
        n_vec++;
        if (stall != 0) begin
            n_err++;
            $display("FAIL bp_early_stall got %0d stalls want 0", stall);
        end
        axis.s_axis_bit_tdata  = 1'b1;
        axis.s_axis_bit_tvalid = 1'b1;
        repeat (3) @(negedge aclk);
        n_vec++;
        if (axis.s_axis_bit_tready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready_p63 got %b want 0",
                     axis.s_axis_bit_tready);
        end
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b1 ||
            axis.m_axis_data_tdata !== 16'd8320) begin
            n_err++;
            $display("FAIL bp_hold got v=%b d=%0d want v=1 d=8320",
                     axis.m_axis_data_tvalid,
                     $signed(axis.m_axis_data_tdata));
        end
        axis.m_axis_data_tready = 1'b1;
        #1;
        n_vec++;
        if (axis.s_axis_bit_tready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready got %b want 1",
                     axis.s_axis_bit_tready);
        end
        @(posedge aclk);
        #1;
        axis.s_axis_bit_tvalid = 1'b0;
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b1 ||
            axis.m_axis_data_tdata !== 16'd16384) begin
            n_err++;
            $display("FAIL bp_next got v=%b d=%0d want v=1 d=16384",
                     axis.m_axis_data_tvalid,
                     $signed(axis.m_axis_data_tdata));
        end
        push_n(1'b1, DECIM);
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b1 ||
            axis.m_axis_data_tdata !== 16'd16384) begin
            n_err++;
            $display("FAIL bp_after got v=%b d=%0d want v=1 d=16384",
                     axis.m_axis_data_tvalid,
                     $signed(axis.m_axis_data_tdata));
        end
    endtask

    task automatic test_gaps;
        int exp_v [3] = '{8320, 16384, 16384};
        logic [WIDTH-1:0] e;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < DECIM; i++) begin
                if (f == 0 && i == DECIM - 1) begin
                    n_vec++;
                    if (axis.m_axis_data_tvalid !== 1'b0) begin
                        n_err++;
                        $display("FAIL gap_early_valid got %b want 0",
                                 axis.m_axis_data_tvalid);
                    end
                end
                push_bit(1'b1);
                if (i == DECIM - 1) begin
                    e = WIDTH'(exp_v[f]);
                    n_vec++;
                    if (axis.m_axis_data_tvalid !== 1'b1 ||
                        axis.m_axis_data_tdata !== e) begin
                        n_err++;
                        $display("FAIL gap[%0d] got v=%b d=%0d want v=1 d=%0d",
                                 f, axis.m_axis_data_tvalid,
                                 $signed(axis.m_axis_data_tdata), $signed(e));
                    end
                end
                if ($urandom_range(0, 99) < 30) idle($urandom_range(1, 3));
            end
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        push_n(1'b1, DECIM);
        axis.m_axis_data_tready = 1'b0;
        push_n(1'b1, 30);
        axis.s_axis_bit_tdata  = 1'b1;
        axis.s_axis_bit_tvalid = 1'b1;
        #2;
        arst_n = 1'b0;
        #1;
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b0 ||
            axis.m_axis_data_tdata !== 16'd0) begin
            n_err++;
            $display("FAIL midrst_clear got v=%b d=%0d want v=0 d=0",
                     axis.m_axis_data_tvalid,
                     $signed(axis.m_axis_data_tdata));
        end
        axis.s_axis_bit_tvalid  = 1'b0;
        axis.m_axis_data_tready = 1'b1;
        @(negedge aclk);
        arst_n = 1'b1;
        @(posedge aclk);
        #1;
        push_n(1'b1, DECIM - 1);
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_early got %b want 0",
                     axis.m_axis_data_tvalid);
        end
        push_bit(1'b1);
        n_vec++;
        if (axis.m_axis_data_tvalid !== 1'b1 ||
            axis.m_axis_data_tdata !== 16'd8320) begin
            n_err++;
            $display("FAIL midrst_restart got v=%b d=%0d want v=1 d=8320",
                     axis.m_axis_data_tvalid,
                     $signed(axis.m_axis_data_tdata));
        end
    endtask

    initial begin
        axis.s_axis_bit_tvalid  = 1'b0;
        axis.s_axis_bit_tdata   = 1'b0;
        axis.m_axis_data_tready = 1'b1;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_loopback();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
